// File: rtl/uart_tx_word.sv
// uart_tx_word: sends a 16-bit word as two UART frames (high byte first), then pulses shipping_done.
// Optional feature macro: UART_TX_PARITY_EN adds an even-parity bit to each frame (8E1).
module uart_tx_word #(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en_uart_tx,
    input  logic [15:0] data_to_send,
    output logic        tx,
    output logic        shipping_done,
    output logic        busy,
    output logic [2:0]  state_dbg
);

    // Handshake: en_uart_tx is a level request held until shipping_done is seen; a word is
    // accepted only from IDLE, and REARM blocks re-acceptance until en_uart_tx has been seen low.
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_DONE   = 3'd5,
        S_REARM  = 3'd6
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic          byte_q, byte_d;
    logic [15:0]   sh_q, sh_d;
    logic          tx_q, tx_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;
    logic          baud_end;
`ifdef UART_TX_PARITY_EN
    logic          par_q, par_d;
`endif

    assign baud_end = (baud_q == BAUD_LAST);

    always_comb begin
        state_d = state_q;
        baud_d  = '0;
        bit_d   = bit_q;
        byte_d  = byte_q;
        sh_d    = sh_q;
        tx_d    = tx_q;
        done_d  = 1'b0;
        busy_d  = busy_q;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (en_uart_tx) begin
                    sh_d    = data_to_send;
                    byte_d  = 1'b0;
                    bit_d   = 3'd0;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
`ifdef UART_TX_PARITY_EN
                    par_d   = 1'b0;
`endif
                    state_d = S_START;
                end
            end
            S_START: begin
                baud_d = baud_end ? '0 : baud_q + 1'b1;
                if (baud_end) begin
                    // The byte in flight always sits in sh_q[15:8], shifted right as bits leave.
                    tx_d       = sh_q[8];
                    sh_d[15:8] = {1'b0, sh_q[15:9]};
`ifdef UART_TX_PARITY_EN
                    par_d      = par_q ^ sh_q[8];
`endif
                    state_d    = S_DATA;
                end
            end
            S_DATA: begin
                baud_d = baud_end ? '0 : baud_q + 1'b1;
                if (baud_end) begin
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        tx_d    = par_q;
                        state_d = S_PARITY;
`else
                        tx_d    = 1'b1;
                        state_d = S_STOP;
`endif
                    end else begin
                        tx_d       = sh_q[8];
                        sh_d[15:8] = {1'b0, sh_q[15:9]};
`ifdef UART_TX_PARITY_EN
                        par_d      = par_q ^ sh_q[8];
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                baud_d = baud_end ? '0 : baud_q + 1'b1;
                if (baud_end) begin
                    tx_d    = 1'b1;
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                baud_d = baud_end ? '0 : baud_q + 1'b1;
                if (baud_end) begin
                    if (!byte_q) begin
                        byte_d     = 1'b1;
                        sh_d[15:8] = sh_q[7:0];
                        tx_d       = 1'b0;
`ifdef UART_TX_PARITY_EN
                        par_d      = 1'b0;
`endif
                        state_d    = S_START;
                    end else begin
                        tx_d    = 1'b1;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_REARM;
            end
            S_REARM: begin
                if (!en_uart_tx) state_d = S_IDLE;
            end
            default: begin
                tx_d    = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= 3'd0;
            byte_q  <= 1'b0;
            sh_q    <= 16'h0000;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            sh_q    <= sh_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign tx            = tx_q;
    assign shipping_done = done_q;
    assign busy          = busy_q;
    assign state_dbg     = state_q;

endmodule

// File: tb/tb_uart_tx_word.sv
// Directed bench for uart_tx_word with CLKS_PER_BIT=4; frame layout follows UART_TX_PARITY_EN.
module tb_uart_tx_word;

  localparam int C = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int NB = 2 * FB;

  logic        clk;
  logic        rst_n;
  logic        en_uart_tx;
  logic [15:0] data_to_send;
  logic        tx;
  logic        shipping_done;
  logic        busy;
  logic [2:0]  state_dbg;

  int n_cmp;
  int n_fail;
  int idle_cnt;

  uart_tx_word #(.CLKS_PER_BIT(C)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en_uart_tx(en_uart_tx),
    .data_to_send(data_to_send),
    .tx(tx),
    .shipping_done(shipping_done),
    .busy(busy),
    .state_dbg(state_dbg)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Accepts w on the next edge (en_uart_tx must already be high), swaps data_to_send to
  // w_after, checks every bit centre, and returns at the sample point where shipping_done is high.
  task automatic run_word(input logic [15:0] w, input logic [15:0] w_after, input string tag);
    logic       bits [0:NB-1];
    logic [7:0] b;
    int         t;
    for (int f = 0; f < 2; f++) begin
      b = (f == 0) ? w[15:8] : w[7:0];
      bits[f*FB] = 1'b0;
      for (int j = 0; j < 8; j++) bits[f*FB + 1 + j] = b[j];
`ifdef UART_TX_PARITY_EN
      bits[f*FB + 9] = ^b;
`endif
      bits[f*FB + FB - 1] = 1'b1;
    end
    tick();
    data_to_send = w_after;
    check_bit({tag, "_tx_after_accept"}, tx, 1'b0);
    check_bit({tag, "_busy_after_accept"}, busy, 1'b1);
    t = 0;
    for (int i = 0; i < NB; i++) begin
      while (t < i * C + 2) begin
        tick();
        t++;
      end
      check_bit($sformatf("%s_bit%0d", tag, i), tx, bits[i]);
      check_bit($sformatf("%s_nodone%0d", tag, i), shipping_done, 1'b0);
    end
    while (t < NB * C - 1) begin
      tick();
      t++;
    end
    check_bit({tag, "_done_early"}, shipping_done, 1'b0);
    tick();
    check_bit({tag, "_done_pulse"}, shipping_done, 1'b1);
    check_bit({tag, "_busy_in_done"}, busy, 1'b1);
    check_bit({tag, "_tx_in_done"}, tx, 1'b1);
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    idle_cnt = 0;
    rst_n = 1'b0;
    en_uart_tx = 1'b0;
    data_to_send = 16'h0000;

    // reset
    tick();
    tick();
    check_bit("rst_tx", tx, 1'b1);
    check_bit("rst_done", shipping_done, 1'b0);
    check_bit("rst_busy", busy, 1'b0);
    check_int("rst_state", int'(state_dbg), 0);
    rst_n = 1'b1;
    tick();
    check_bit("idle_tx", tx, 1'b1);
    check_int("idle_state", int'(state_dbg), 0);

    // basic word
    data_to_send = 16'hA55A;
    en_uart_tx = 1'b1;
    run_word(16'hA55A, 16'hA55A, "basic");

    // rearm: request left high after the pulse
    tick();
    check_bit("done_width", shipping_done, 1'b0);
    for (int i = 0; i < 20; i++) begin
      tick();
      check_bit($sformatf("rearm_tx%0d", i), tx, 1'b1);
      check_bit($sformatf("rearm_busy%0d", i), busy, 1'b0);
    end
    check_int("rearm_state", int'(state_dbg), 6);
    en_uart_tx = 1'b0;
    tick();
    check_int("rearm_exit_state", int'(state_dbg), 0);

    // data stability after accept
    data_to_send = 16'h1234;
    en_uart_tx = 1'b1;
    run_word(16'h1234, 16'hFFFF, "stable");

    // back-to-back with scheduler model
    tick();
    if (busy === 1'b0 && tx === 1'b1) idle_cnt++;
    en_uart_tx = 1'b0;
    tick();
    if (busy === 1'b0 && tx === 1'b1) idle_cnt++;
    en_uart_tx = 1'b1;
    data_to_send = 16'h0000;
    run_word(16'h0000, 16'h0000, "b2b_zero");
    check_int("b2b_idle_cycles", idle_cnt, 2);

`ifdef UART_TX_PARITY_EN
    tick();
    en_uart_tx = 1'b0;
    tick();
    en_uart_tx = 1'b1;
    data_to_send = 16'h0701;
    run_word(16'h0701, 16'h0701, "parity");
`endif

    // mid-word reset in DATA of byte 2
    tick();
    en_uart_tx = 1'b0;
    tick();
    data_to_send = 16'hABCD;
    en_uart_tx = 1'b1;
    tick();
    for (int t = 0; t < FB * C + 3 * C + 2; t++) tick();
    check_int("midrst_in_data", int'(state_dbg), 2);
    #2;
    rst_n = 1'b0;
    #1;
    check_bit("midrst_tx", tx, 1'b1);
    check_bit("midrst_busy", busy, 1'b0);
    check_int("midrst_state", int'(state_dbg), 0);
    for (int i = 0; i < 4 * C; i++) begin
      tick();
      check_bit($sformatf("midrst_nodone%0d", i), shipping_done, 1'b0);
      check_bit($sformatf("midrst_tx_hold%0d", i), tx, 1'b1);
    end
    data_to_send = 16'h00FF;
    rst_n = 1'b1;
    run_word(16'h00FF, 16'h00FF, "post_rst");

    tick();
    en_uart_tx = 1'b0;
    tick();
    check_int("final_state", int'(state_dbg), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
